// File: rtl/cardinal_nic_pkg.sv
// Shared constants and helpers for the cardinal NIC: register map, packet fields, status layout.
package cardinal_nic_pkg;

  localparam int unsigned NIC_DATA_WIDTH = 64;

  // CPU register map
  localparam logic [0:1] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [0:1] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [0:1] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [0:1] NIC_ADDR_OUT_STAT = 2'b11;

  // Bit 0 is the MSB throughout (big-endian bit order)
  localparam int unsigned VC_BIT          = 0;
  localparam int unsigned STATUS_FULL_BIT = 63;

  // Packet field positions
  localparam int unsigned DIR_LO     = 1;
  localparam int unsigned DIR_HI     = 2;
  localparam int unsigned HOP_LO     = 8;
  localparam int unsigned HOP_HI     = 15;
  localparam int unsigned SRC_LO     = 16;
  localparam int unsigned SRC_HI     = 31;
  localparam int unsigned PAYLOAD_LO = 32;
  localparam int unsigned PAYLOAD_HI = 63;

  // Status word: all zeros except the full flag in bit STATUS_FULL_BIT
  function automatic logic [0:NIC_DATA_WIDTH-1] status_word(input logic full);
    logic [0:NIC_DATA_WIDTH-1] w;
    w = '0;
    w[STATUS_FULL_BIT] = full;
    return w;
  endfunction

endpackage

// File: rtl/nic_channel_buf.sv
// Single-entry packet buffer with a full flag. A load only lands when empty; load beats clear.
module nic_channel_buf #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [0:DATA_WIDTH-1] d,
  output logic [0:DATA_WIDTH-1] q,
  output logic                  full
);

  // Buffer contents and occupancy, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load && !full) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: memory-mapped bridge between a CPU data port and the local mesh router.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  logic [0:DATA_WIDTH-1] in_buf;
  logic [0:DATA_WIDTH-1] out_buf;
  logic                  in_full;
  logic                  out_full;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic                  in_load;
  logic                  in_clear;
  logic                  out_load;

  assign cpu_rd = nicEn && !nicWrEn;
  assign cpu_wr = nicEn && nicWrEn;

  // A read of in_buf frees the slot; an arrival into an empty slot takes priority inside the buffer
  assign in_load  = net_si;
  assign in_clear = cpu_rd && (addr == NIC_ADDR_IN_BUF);
  // Writes while full are dropped inside the buffer, including the injection cycle
  assign out_load = cpu_wr && (addr == NIC_ADDR_OUT_BUF);

  assign net_ri = ~in_full;
  assign net_so = out_full && net_ro && (out_buf[VC_BIT] == net_polarity);
  assign net_do = out_buf;

  nic_channel_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_in_buf (
    .clk  (clk),
    .reset(reset),
    .load (in_load),
    .clear(in_clear),
    .d    (net_di),
    .q    (in_buf),
    .full (in_full)
  );

  nic_channel_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk  (clk),
    .reset(reset),
    .load (out_load),
    .clear(net_so),
    .d    (d_in),
    .q    (out_buf),
    .full (out_full)
  );

  // Registered CPU read data; holds when no read is issued
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_out <= '0;
    end else if (cpu_rd) begin
      case (addr)
        NIC_ADDR_IN_BUF:   d_out <= in_buf;
        NIC_ADDR_IN_STAT:  d_out <= DATA_WIDTH'(status_word(in_full));
        NIC_ADDR_OUT_STAT: d_out <= DATA_WIDTH'(status_word(out_full));
        default:           d_out <= '0;
      endcase
    end
  end

endmodule
